// File: rtl/tc_clk_pkg.sv
// Shared types and constants for the multi-channel clock divider.
package tc_clk_pkg;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StStop = 2'd2;

    typedef enum logic [1:0] {
        IDLE = StIdle,
        RUN  = StRun,
        STOP = StStop
    } chan_state_e;

    localparam int DivMin = 1;

endpackage

// File: rtl/tc_clk_div_chan.sv
// One divider channel: counter, run/stop FSM, pending ratio register and duty logic.
// TC_CLK_DIV_ODD_DUTY50_EN adds a falling-edge flop giving exact 50% duty on odd ratios.
module tc_clk_div_chan
    import tc_clk_pkg::*;
#(
    parameter int DivWidth   = 8,
    parameter int DefaultDiv = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                cfg_we_i,
    input  logic [DivWidth-1:0] cfg_div_i,
    output logic                pend_o,
    output logic                clk_o,
    output logic                clk_en_o,
    output logic                busy_o
);

    typedef logic [DivWidth-1:0] div_t;
    localparam div_t DivOne = div_t'(DivMin);

    chan_state_e state_q, state_d;
    div_t        cnt_q, cnt_d;
    div_t        div_q, div_d;
    div_t        pdiv_q, pdiv_d;
    logic        pend_q, pend_d;
    logic        clk_q, clk_d;
    logic        wrap;
    logic        gate_en;
    logic        gate_lat;
    logic        div_clk;

    assign wrap = (state_q != IDLE) && (cnt_q == div_q - DivOne);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        pdiv_d  = pdiv_q;
        pend_d  = pend_q;
        if (state_q == IDLE) begin
            cnt_d   = '0;
            state_d = en_i ? RUN : IDLE;
        end else begin
            cnt_d   = wrap ? '0 : cnt_q + DivOne;
            state_d = en_i ? RUN : (wrap ? IDLE : STOP);
        end
        // A new ratio only lands on a period boundary so the output never glitches
        if (pend_q && ((state_q == IDLE) || wrap)) begin
            div_d  = pdiv_q;
            pend_d = 1'b0;
        end
        if (cfg_we_i) begin
            pend_d = 1'b1;
            pdiv_d = (cfg_div_i == '0) ? DivOne : cfg_div_i;
        end
        // Computed from next-state values so clk_q lines up with cnt_q
        clk_d = (state_d != IDLE) && (cnt_d < (div_d >> 1));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= div_t'(DefaultDiv);
            pdiv_q  <= div_t'(DefaultDiv);
            pend_q  <= 1'b0;
            clk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pdiv_q  <= pdiv_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
        end
    end

    // Divide-by-one: ICG-style gate, enable captured while clk_i is low
    assign gate_en = rst_ni && (state_d != IDLE) && (div_d == DivOne);

    always_latch begin
        if (!clk_i) gate_lat <= gate_en;
    end

`ifdef TC_CLK_DIV_ODD_DUTY50_EN
    logic half_q, half_d;

    always_comb half_d = clk_q;

    always_ff @(negedge clk_i) begin
        if (!rst_ni) half_q <= 1'b0;
        else         half_q <= half_d;
    end

    assign div_clk = (div_q[0] && (div_q != DivOne)) ? (clk_q | half_q) : clk_q;
`else
    assign div_clk = clk_q;
`endif

    assign clk_o    = (div_q == DivOne) ? (clk_i & gate_lat) : div_clk;
    assign clk_en_o = wrap;
    assign busy_o   = (state_q != IDLE);
    assign pend_o   = pend_q;

endmodule

// File: rtl/tc_clk_div_multi.sv
// Multi-channel programmable clock divider: config decode, ready mux and scan bypass.
// Optional TC_CLK_DIV_ODD_DUTY50_EN is handled inside each channel.
module tc_clk_div_multi
    import tc_clk_pkg::*;
#(
    parameter int NumChannels  = 4,
    parameter int DivWidth     = 8,
    parameter int DefaultDiv   = 2,
    localparam int ChW         = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   test_en_i,
    input  logic [NumChannels-1:0] ch_en_i,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic [ChW-1:0]         cfg_ch_i,
    input  logic [DivWidth-1:0]    cfg_div_i,
    output logic [NumChannels-1:0] clk_o,
    output logic [NumChannels-1:0] clk_en_o,
    output logic [NumChannels-1:0] busy_o
);

    logic [NumChannels-1:0] pend;
    logic [NumChannels-1:0] cfg_we;
    logic [NumChannels-1:0] div_clk;

    // Channels that do not exist never block, so their writes are accepted and dropped
    always_comb begin
        cfg_ready_o = 1'b1;
        for (int c = 0; c < NumChannels; c++) begin
            if ((cfg_ch_i == ChW'(c)) && pend[c]) cfg_ready_o = 1'b0;
        end
    end

    for (genvar c = 0; c < NumChannels; c++) begin : g_chan
        assign cfg_we[c] = cfg_valid_i && cfg_ready_o && (cfg_ch_i == ChW'(c));

        tc_clk_div_chan #(
            .DivWidth   (DivWidth),
            .DefaultDiv (DefaultDiv)
        ) u_chan (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .en_i      (ch_en_i[c]),
            .cfg_we_i  (cfg_we[c]),
            .cfg_div_i (cfg_div_i),
            .pend_o    (pend[c]),
            .clk_o     (div_clk[c]),
            .clk_en_o  (clk_en_o[c]),
            .busy_o    (busy_o[c])
        );

        assign clk_o[c] = test_en_i ? clk_i : div_clk[c];
    end

endmodule

// File: tb/tb_tc_clk_div_multi.sv
// Scoreboard bench for tc_clk_div_multi: expected per-cycle channel outputs are queued, then popped.
module tb_tc_clk_div_multi;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       test_en_i;
    logic [3:0] ch_en_i;
    logic       cfg_valid_i;
    logic       cfg_ready_o;
    logic [1:0] cfg_ch_i;
    logic [7:0] cfg_div_i;
    logic [3:0] clk_o;
    logic [3:0] clk_en_o;
    logic [3:0] busy_o;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic hi;
        logic lo;
        logic en;
        logic busy;
    } exp_t;

    exp_t sb_q[$];

    tc_clk_div_multi #(
        .NumChannels (4),
        .DivWidth    (8),
        .DefaultDiv  (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .test_en_i   (test_en_i),
        .ch_en_i     (ch_en_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_ch_i    (cfg_ch_i),
        .cfg_div_i   (cfg_div_i),
        .clk_o       (clk_o),
        .clk_en_o    (clk_en_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end (time %0t)", $time);
        $fatal(1);
    end

    // Expected outputs of a running channel at counter value cnt for ratio div
    function automatic void push_cnt(input int div, input int cnt);
        exp_t e;
        if (div <= 1) begin
            e.hi = 1'b1;
            e.lo = 1'b0;
        end else begin
            e.lo = (cnt < div / 2);
            e.hi = e.lo;
`ifdef TC_CLK_DIV_ODD_DUTY50_EN
            if ((div % 2 == 1) && (cnt == div / 2)) e.hi = 1'b1;
`endif
        end
        e.en   = (cnt == ((div <= 1) ? 0 : div - 1));
        e.busy = 1'b1;
        sb_q.push_back(e);
    endfunction

    function automatic void push_period(input int div);
        for (int i = 0; i < div; i++) push_cnt(div, i);
    endfunction

    function automatic void push_idle();
        sb_q.push_back(4'b0000);
    endfunction

    // One clock cycle: high-phase and low-phase views of a channel
    task automatic sample(input int ch, output logic hi, output logic lo,
                          output logic en, output logic bz);
        @(posedge clk_i); #1;
        hi = clk_o[ch];
        @(negedge clk_i); #1;
        lo = clk_o[ch];
        en = clk_en_o[ch];
        bz = busy_o[ch];
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk_i); #1;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; test_en_i = 1'b0; ch_en_i = '0;
        cfg_valid_i = 1'b0; cfg_ch_i = '0; cfg_div_i = '0;
        idle_cycles(3);
        checks++;
        if (clk_o !== 4'h0) begin failures++; $display("FAIL reset_clk_o got=%h exp=0", clk_o); end
        checks++;
        if (clk_en_o !== 4'h0) begin failures++; $display("FAIL reset_clk_en got=%h exp=0", clk_en_o); end
        checks++;
        if (busy_o !== 4'h0) begin failures++; $display("FAIL reset_busy got=%h exp=0", busy_o); end
        checks++;
        if (cfg_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cfg_ready_o); end
        rst_ni = 1'b1;
        idle_cycles(1);
    endtask

    task automatic test_div2();
        logic hi, lo, en, bz;
        exp_t e;
        ch_en_i[0] = 1'b1;
        for (int i = 0; i < 3; i++) push_period(2);
        while (sb_q.size() > 0) begin
            sample(0, hi, lo, en, bz);
            e = sb_q.pop_front();
            checks++;
            if ({hi, lo, en, bz} !== e) begin
                failures++;
                $display("FAIL div2_ch0 got hi/lo/en/busy=%b%b%b%b exp=%b", hi, lo, en, bz, e);
            end
        end
    endtask

    task automatic test_ratio_update();
        logic hi, lo, en, bz;
        exp_t e;
        cfg_valid_i = 1'b1; cfg_ch_i = 2'd1; cfg_div_i = 8'd4;
        checks++;
        if (cfg_ready_o !== 1'b1) begin failures++; $display("FAIL ratio_ready_idle got=%b exp=1", cfg_ready_o); end
        idle_cycles(1);
        cfg_valid_i = 1'b0;
        checks++;
        if (cfg_ready_o !== 1'b0) begin failures++; $display("FAIL ratio_ready_pend got=%b exp=0", cfg_ready_o); end
        idle_cycles(1);
        checks++;
        if ({cfg_ready_o, busy_o[1]} !== 2'b10) begin
            failures++; $display("FAIL ratio_idle_apply got ready/busy=%b%b exp=10", cfg_ready_o, busy_o[1]);
        end
        ch_en_i[1] = 1'b1;
        for (int i = 0; i < 3; i++) push_cnt(4, i);
        for (int step = 0; step < 2; step++) begin
            while (sb_q.size() > 0) begin
                sample(1, hi, lo, en, bz);
                e = sb_q.pop_front();
                checks++;
                if ({hi, lo, en, bz} !== e) begin
                    failures++;
                    $display("FAIL ratio_ch1 step%0d got hi/lo/en/busy=%b%b%b%b exp=%b", step, hi, lo, en, bz, e);
                end
            end
            if (step == 0) begin
                // Request div=5 while the counter sits at 2
                cfg_valid_i = 1'b1; cfg_div_i = 8'd5;
                push_cnt(4, 3);
                sample(1, hi, lo, en, bz);
                e = sb_q.pop_front();
                checks++;
                if ({hi, lo, en, bz} !== e) begin
                    failures++;
                    $display("FAIL ratio_ch1_cnt3 got hi/lo/en/busy=%b%b%b%b exp=%b", hi, lo, en, bz, e);
                end
                checks++;
                if (cfg_ready_o !== 1'b0) begin failures++; $display("FAIL ratio_ready_run got=%b exp=0", cfg_ready_o); end
                cfg_valid_i = 1'b0;
                push_period(5);
                push_period(5);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic hi, lo, en, bz;
        exp_t e;
        ch_en_i[2] = 1'b1;
        for (int step = 0; step < 5; step++) begin
            case (step)
                0: push_cnt(2, 0);
                1: push_cnt(2, 1);
                2: push_cnt(4, 0);
                3: push_cnt(4, 1);
                default: begin
                    push_cnt(4, 2); push_cnt(4, 3);
                    push_period(6); push_period(6);
                end
            endcase
            while (sb_q.size() > 0) begin
                sample(2, hi, lo, en, bz);
                e = sb_q.pop_front();
                checks++;
                if ({hi, lo, en, bz} !== e) begin
                    failures++;
                    $display("FAIL b2b_ch2 step%0d got hi/lo/en/busy=%b%b%b%b exp=%b", step, hi, lo, en, bz, e);
                end
            end
            case (step)
                0: begin
                    cfg_valid_i = 1'b1; cfg_ch_i = 2'd2; cfg_div_i = 8'd4;
                    checks++;
                    if (cfg_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready_first got=%b exp=1", cfg_ready_o); end
                end
                1: begin
                    cfg_div_i = 8'd6;
                    checks++;
                    if (cfg_ready_o !== 1'b0) begin failures++; $display("FAIL b2b_ready_stall got=%b exp=0", cfg_ready_o); end
                end
                2: begin
                    checks++;
                    if (cfg_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready_after_wrap got=%b exp=1", cfg_ready_o); end
                end
                3: begin
                    cfg_valid_i = 1'b0;
                    checks++;
                    if (cfg_ready_o !== 1'b0) begin failures++; $display("FAIL b2b_ready_second got=%b exp=0", cfg_ready_o); end
                end
                default: begin
                    checks++;
                    if (cfg_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready_end got=%b exp=1", cfg_ready_o); end
                end
            endcase
        end
    endtask

    task automatic test_stop_restart();
        logic hi, lo, en, bz;
        exp_t e;
        cfg_valid_i = 1'b1; cfg_ch_i = 2'd3; cfg_div_i = 8'd8;
        idle_cycles(1);
        cfg_valid_i = 1'b0;
        idle_cycles(1);
        ch_en_i[3] = 1'b1;
        for (int step = 0; step < 5; step++) begin
            case (step)
                0: begin push_cnt(8, 0); push_cnt(8, 1); end
                1: begin
                    for (int i = 2; i < 8; i++) push_cnt(8, i);
                    push_idle(); push_idle();
                end
                2: for (int i = 0; i < 3; i++) push_cnt(8, i);
                3: push_cnt(8, 3);
                default: begin
                    for (int i = 4; i < 8; i++) push_cnt(8, i);
                    push_period(8);
                end
            endcase
            while (sb_q.size() > 0) begin
                sample(3, hi, lo, en, bz);
                e = sb_q.pop_front();
                checks++;
                if ({hi, lo, en, bz} !== e) begin
                    failures++;
                    $display("FAIL stop_ch3 step%0d got hi/lo/en/busy=%b%b%b%b exp=%b", step, hi, lo, en, bz, e);
                end
            end
            case (step)
                0: ch_en_i[3] = 1'b0;
                1: ch_en_i[3] = 1'b1;
                2: ch_en_i[3] = 1'b0;
                3: ch_en_i[3] = 1'b1;
                default: ;
            endcase
        end
    endtask

    task automatic test_div0();
        logic hi, lo, en, bz;
        exp_t e;
        ch_en_i[0] = 1'b0;
        idle_cycles(3);
        checks++;
        if (busy_o[0] !== 1'b0) begin failures++; $display("FAIL div0_stopped_busy got=%b exp=0", busy_o[0]); end
        cfg_valid_i = 1'b1; cfg_ch_i = 2'd0; cfg_div_i = 8'd0;
        idle_cycles(1);
        cfg_valid_i = 1'b0;
        idle_cycles(1);
        for (int step = 0; step < 2; step++) begin
            if (step == 0) push_idle();
            else for (int i = 0; i < 6; i++) push_cnt(1, 0);
            while (sb_q.size() > 0) begin
                sample(0, hi, lo, en, bz);
                e = sb_q.pop_front();
                checks++;
                if ({hi, lo, en, bz} !== e) begin
                    failures++;
                    $display("FAIL div0_ch0 step%0d got hi/lo/en/busy=%b%b%b%b exp=%b", step, hi, lo, en, bz, e);
                end
            end
            ch_en_i[0] = 1'b1;
        end
    endtask

    task automatic test_reset_bypass();
        logic hi, lo, en, bz;
        exp_t e;
        cfg_valid_i = 1'b1; cfg_ch_i = 2'd3; cfg_div_i = 8'd3;
        idle_cycles(1);
        cfg_valid_i = 1'b0;
        checks++;
        if (cfg_ready_o !== 1'b0) begin failures++; $display("FAIL rst_pend_before got=%b exp=0", cfg_ready_o); end
        test_en_i = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (clk_o !== 4'hF) begin failures++; $display("FAIL bypass_high got=%h exp=f", clk_o); end
        @(negedge clk_i); #1;
        checks++;
        if (clk_o !== 4'h0) begin failures++; $display("FAIL bypass_low got=%h exp=0", clk_o); end
        rst_ni = 1'b0; ch_en_i = '0;
        @(posedge clk_i); #1;
        checks++;
        if (clk_o !== 4'hF) begin failures++; $display("FAIL bypass_in_reset got=%h exp=f", clk_o); end
        @(negedge clk_i); #1;
        checks++;
        if ({clk_o, clk_en_o, busy_o, cfg_ready_o} !== 13'h0001) begin
            failures++;
            $display("FAIL rst_mid_period got clk/en/busy=%h/%h/%h ready=%b exp 0/0/0 ready=1",
                     clk_o, clk_en_o, busy_o, cfg_ready_o);
        end
        test_en_i = 1'b0;
        @(posedge clk_i); #1;
        checks++;
        if (clk_o !== 4'h0) begin failures++; $display("FAIL rst_clk_high_phase got=%h exp=0", clk_o); end
        @(negedge clk_i); #1;
        rst_ni = 1'b1; ch_en_i = 4'b0010;
        push_period(2);
        push_period(2);
        while (sb_q.size() > 0) begin
            sample(1, hi, lo, en, bz);
            e = sb_q.pop_front();
            checks++;
            if ({hi, lo, en, bz} !== e) begin
                failures++;
                $display("FAIL rst_default_div_ch1 got hi/lo/en/busy=%b%b%b%b exp=%b", hi, lo, en, bz, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_div2();
        test_ratio_update();
        test_back_to_back();
        test_stop_restart();
        test_div0();
        test_reset_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
